sensor_reg_bank: RTL and testbench
==================================

SENSOR_REG_BANK -- requirements
Module: sensor_reg_bank

Interface
REQ-001 The block SHALL have parameter NUM_SENSORS, default 7, meaning number of read-only sensor capture registers (1..16).
REQ-002 The block SHALL have parameter NUM_LEDS, default 3, meaning number of read/write LED control registers (1..8).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 The port list SHALL be, in order:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- address  in  24  ARM byte address
- data_in  in  32  write data
- data_out  out  32  read data, registered
- ws_n  in  1  write strobe, active low
- rs_n  in  1  read strobe, active low
- be  in  4  byte enables, be[k] covers data_in[8k+7:8k]
- as  in  1  chip select, active high
- sensor_data  in  32*NUM_SENSORS  sensor i word at [32i+31:32i]
- sensor_valid  in  NUM_SENSORS  one-cycle capture pulse per sensor
- led_out  out  32*NUM_LEDS  LED register j at [32j+31:32j]
- irq  out  1  interrupt, present only under SENSOR_IRQ_EN

Function
REQ-005 The address map SHALL be word-aligned: sensor i at 4*i; LED j at 4*(NUM_SENSORS+j); STATUS at 4*(NUM_SENSORS+NUM_LEDS); IRQ_MASK at STATUS+4 (macro only).
REQ-006 An address with address[1:0]!=0 or outside the map SHALL be unmapped: reads return 32'h0BADADD0, writes have no effect.
REQ-007 The bus FSM SHALL have states IDLE and DONE; IDLE->DONE on a clock edge with as=1 and (rs_n=0 or ws_n=0); DONE->IDLE on an edge with as=0; no other transitions.
REQ-008 Exactly one access SHALL execute per IDLE->DONE transition; strobes held low in DONE SHALL be ignored.
REQ-009 A read SHALL update data_out on the same edge as IDLE->DONE (1-cycle latency); data_out SHALL hold its value otherwise.
REQ-010 If rs_n and ws_n are both low in IDLE, the read SHALL execute and the write SHALL be dropped.
REQ-011 A write to an LED register SHALL update only the bytes with be[k]=1; be=4'b0000 SHALL leave the register unchanged but still enter DONE.
REQ-012 Writes to sensor or STATUS addresses SHALL be ignored.
REQ-013 On each edge with sensor_valid[i]=1, sensor register i SHALL load the sensor i word and STATUS bit i SHALL be set.
REQ-014 STATUS bits [NUM_SENSORS-1:0] SHALL be sticky; upper bits SHALL read 0.
REQ-015 A STATUS read SHALL return the pre-edge bits and clear them on the same edge; a set from sensor_valid on that edge SHALL win over the clear.
REQ-016 A sensor read coinciding with a capture of the same sensor SHALL return the old value.
REQ-017 led_out SHALL reflect the LED registers directly with no added latency.

Reset
REQ-018 On rst_n low, the block SHALL asynchronously set data_out=32'hFEE1DEAD, the FSM to IDLE, and all sensor, LED, STATUS, IRQ_MASK registers and irq to 0.
REQ-019 Reset asserted mid-access SHALL abort the access, and the next access SHALL require a fresh IDLE->DONE transition.

Configuration
REQ-020 With macro SENSOR_IRQ_EN defined, the block SHALL provide the irq port and the IRQ_MASK register (R/W, be-qualified), with irq registered as |(STATUS & IRQ_MASK) and one cycle behind STATUS.
REQ-021 Without SENSOR_IRQ_EN, the block SHALL have neither the irq port nor the IRQ_MASK register, and the IRQ_MASK address SHALL be unmapped.

Structure
REQ-022 Package sensor_reg_pkg SHALL hold the FSM state typedef, the constants RESET_DATA=32'hFEE1DEAD and UNMAPPED_DATA=32'h0BADADD0, and the address-offset helper functions.
REQ-023 The bus FSM and single-access qualification SHALL be a sub-module named bus_access_fsm, outputting one-cycle rd_go and wr_go pulses.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then read address 0 -> data_out=0; before any read, data_out=32'hFEE1DEAD.
- Write 32'hA5A5A5A5 to LED0 with be=4'b0101, starting from 0 -> led_out[31:0]=32'h00A500A5.
- sensor_valid[2] pulse with data 32'h12345678, read STATUS -> 32'h4; second STATUS read -> 0; read 8 -> 32'h12345678.
- Hold as=1, rs_n=0 for 5 cycles while STATUS bit 0 is set -> one read only, bit cleared once, FSM stays DONE until as=0.
- Read address 0x3 and 0x400 -> 32'h0BADADD0; write to sensor 0 -> value unchanged.
- With SENSOR_IRQ_EN: IRQ_MASK=1, pulse sensor_valid[0] -> irq=1 one cycle after STATUS sets; STATUS read -> irq=0 the following cycle.

Source files
------------

// File: rtl/sensor_reg_pkg.sv
// Shared types, constants and address-map helpers for the sensor register bank.
package sensor_reg_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [DATA_W-1:0] RESET_DATA    = 32'hFEE1DEAD;
    localparam logic [DATA_W-1:0] UNMAPPED_DATA = 32'h0BADADD0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } bus_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } bus_req_t;

    function automatic logic [ADDR_W-1:0] sensor_addr(input int unsigned i);
        return ADDR_W'(4 * i);
    endfunction

    function automatic logic [ADDR_W-1:0] led_addr(input int unsigned num_sensors,
                                                   input int unsigned j);
        return ADDR_W'(4 * (num_sensors + j));
    endfunction

    function automatic logic [ADDR_W-1:0] status_addr(input int unsigned num_sensors,
                                                      input int unsigned num_leds);
        return ADDR_W'(4 * (num_sensors + num_leds));
    endfunction

    function automatic logic [ADDR_W-1:0] irq_mask_addr(input int unsigned num_sensors,
                                                        input int unsigned num_leds);
        return ADDR_W'(4 * (num_sensors + num_leds + 1));
    endfunction

    // Replace only the byte lanes whose enable is set.
    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] cur,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [BE_W-1:0]   lanes);
        logic [DATA_W-1:0] r;
        r = cur;
        for (int k = 0; k < 4; k++) begin
            if (lanes[k]) r[8*k +: 8] = wdata[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_access_fsm.sv
// Bus handshake FSM: qualifies exactly one read or write per IDLE->DONE transition.
module bus_access_fsm
    import sensor_reg_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic as,
    input  logic rs_n,
    input  logic ws_n,
    output logic rd_go,
    output logic wr_go
);

    bus_state_e state;
    logic       start;

    // Pulses fire in the cycle that ends in the IDLE->DONE edge; read wins a tie.
    assign start = (state == ST_IDLE) && as && (!rs_n || !ws_n);
    assign rd_go = start && !rs_n;
    assign wr_go = start && rs_n && !ws_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_DONE;
                ST_DONE: if (!as)   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sensor_reg_bank.sv
// Memory-mapped bank of sensor capture registers, LED control registers and a sticky STATUS.
// Optional SENSOR_IRQ_EN adds an IRQ_MASK register and a registered irq output.
module sensor_reg_bank
    import sensor_reg_pkg::*;
#(
    parameter int unsigned NUM_SENSORS = 7,
    parameter int unsigned NUM_LEDS    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [23:0]               address,
    input  logic [31:0]               data_in,
    output logic [31:0]               data_out,
    input  logic                      ws_n,
    input  logic                      rs_n,
    input  logic [3:0]                be,
    input  logic                      as,
    input  logic [32*NUM_SENSORS-1:0] sensor_data,
    input  logic [NUM_SENSORS-1:0]    sensor_valid,
    output logic [32*NUM_LEDS-1:0]    led_out
`ifdef SENSOR_IRQ_EN
    ,
    output logic                      irq
`endif
);

    bus_req_t               req;
    logic                   rd_go;
    logic                   wr_go;
    logic [31:0]            rd_data_c;
    logic                   status_hit_c;
    logic [NUM_SENSORS-1:0] status_d;
    logic [NUM_SENSORS-1:0] status_q;
    logic [31:0]            sensor_q [NUM_SENSORS];
    logic [31:0]            led_q    [NUM_LEDS];
`ifdef SENSOR_IRQ_EN
    logic [31:0]            irq_mask_q;
`endif

    assign req = '{addr: address, data: data_in, be: be};

    bus_access_fsm u_fsm (
        .clk   (clk),
        .rst_n (rst_n),
        .as    (as),
        .rs_n  (rs_n),
        .ws_n  (ws_n),
        .rd_go (rd_go),
        .wr_go (wr_go)
    );

    // Read mux: full-address compare, so misaligned addresses fall through to UNMAPPED_DATA.
    always_comb begin
        rd_data_c = UNMAPPED_DATA;
        for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
            if (req.addr == sensor_addr(i)) rd_data_c = sensor_q[i];
        end
        for (int unsigned j = 0; j < NUM_LEDS; j++) begin
            if (req.addr == led_addr(NUM_SENSORS, j)) rd_data_c = led_q[j];
        end
        if (req.addr == status_addr(NUM_SENSORS, NUM_LEDS)) rd_data_c = 32'(status_q);
`ifdef SENSOR_IRQ_EN
        if (req.addr == irq_mask_addr(NUM_SENSORS, NUM_LEDS)) rd_data_c = irq_mask_q;
`endif
    end

    // Read-to-clear, with a same-edge capture taking priority.
    assign status_hit_c = (req.addr == status_addr(NUM_SENSORS, NUM_LEDS));
    assign status_d     = ((rd_go && status_hit_c) ? '0 : status_q) | sensor_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= RESET_DATA;
            status_q <= '0;
        end else begin
            if (rd_go) data_out <= rd_data_c;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SENSORS; i++) sensor_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
                if (sensor_valid[i]) sensor_q[i] <= sensor_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < NUM_LEDS; j++) led_q[j] <= '0;
        end else if (wr_go) begin
            for (int unsigned j = 0; j < NUM_LEDS; j++) begin
                if (req.addr == led_addr(NUM_SENSORS, j))
                    led_q[j] <= byte_merge(led_q[j], req.data, req.be);
            end
        end
    end

    for (genvar j = 0; j < NUM_LEDS; j++) begin : g_led
        assign led_out[32*j +: 32] = led_q[j];
    end

`ifdef SENSOR_IRQ_EN
    // irq follows the registered STATUS, so it lags STATUS by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mask_q <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_go && (req.addr == irq_mask_addr(NUM_SENSORS, NUM_LEDS)))
                irq_mask_q <= byte_merge(irq_mask_q, req.data, req.be);
            irq <= |(status_q & irq_mask_q[NUM_SENSORS-1:0]);
        end
    end
`endif

endmodule

// File: tb/tb_sensor_reg_bank.sv
// Self-checking bench for sensor_reg_bank: directed scenarios plus random traffic
// against a behavioural register-map model. Builds with or without SENSOR_IRQ_EN.
module tb_sensor_reg_bank;

    localparam int unsigned NS = 7;
    localparam int unsigned NL = 3;
    localparam logic [23:0] A_LED0   = 24'(4 * NS);
    localparam logic [23:0] A_LED1   = 24'(4 * NS + 4);
    localparam logic [23:0] A_STATUS = 24'(4 * (NS + NL));
    localparam logic [23:0] A_MASK   = 24'(4 * (NS + NL) + 4);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [23:0]      address;
    logic [31:0]      data_in;
    logic [31:0]      data_out;
    logic             ws_n;
    logic             rs_n;
    logic [3:0]       be;
    logic             as;
    logic [32*NS-1:0] sensor_data;
    logic [NS-1:0]    sensor_valid;
    logic [32*NL-1:0] led_out;
`ifdef SENSOR_IRQ_EN
    logic             irq;
`endif

    always #5 clk = ~clk;

    sensor_reg_bank #(.NUM_SENSORS(NS), .NUM_LEDS(NL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .ws_n         (ws_n),
        .rs_n         (rs_n),
        .be           (be),
        .as           (as),
        .sensor_data  (sensor_data),
        .sensor_valid (sensor_valid),
        .led_out      (led_out)
`ifdef SENSOR_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_sensor [NS];
    logic [31:0] m_led    [NL];
    logic [NS-1:0] m_status;
    logic [31:0] m_mask;
    logic [31:0] m_data_out;
    logic        m_irq;
    bit          m_busy;
    bit          rnd_sensors;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Region kind: 0 unmapped, 1 sensor, 2 led, 3 status, 4 irq mask
    function automatic int decode(input logic [23:0] a, output int idx);
        int w;
        w = int'(a >> 2);
        idx = 0;
        if (a[1:0] != 2'b00) return 0;
        if (w < int'(NS)) begin idx = w; return 1; end
        if (w < int'(NS + NL)) begin idx = w - int'(NS); return 2; end
        if (w == int'(NS + NL)) return 3;
`ifdef SENSOR_IRQ_EN
        if (w == int'(NS + NL + 1)) return 4;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NS); i++) m_sensor[i] = '0;
        for (int j = 0; j < int'(NL); j++) m_led[j] = '0;
        m_status   = '0;
        m_mask     = '0;
        m_data_out = 32'hFEE1DEAD;
        m_irq      = 1'b0;
        m_busy     = 1'b0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        bit            start;
        int            kind;
        int            idx;
        logic [NS-1:0] nstat;
        logic          nirq;
        start = !m_busy && as && (!rs_n || !ws_n);
        nstat = m_status;
        nirq  = |(m_status & m_mask[NS-1:0]);
        kind  = decode(address, idx);
        if (start && !rs_n) begin
            case (kind)
                1: m_data_out = m_sensor[idx];
                2: m_data_out = m_led[idx];
                3: begin m_data_out = 32'(m_status); nstat = '0; end
                4: m_data_out = m_mask;
                default: m_data_out = 32'h0BADADD0;
            endcase
        end else if (start && !ws_n) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    if (kind == 2) m_led[idx][8*k +: 8] = data_in[8*k +: 8];
                    if (kind == 4) m_mask[8*k +: 8] = data_in[8*k +: 8];
                end
            end
        end
        for (int i = 0; i < int'(NS); i++) begin
            if (sensor_valid[i]) begin
                m_sensor[i] = sensor_data[32*i +: 32];
                nstat[i] = 1'b1;
            end
        end
        m_status = nstat;
        m_irq    = nirq;
        if (start) m_busy = 1'b1;
        else if (m_busy && !as) m_busy = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "/data_out"}, data_out, m_data_out);
        for (int j = 0; j < int'(NL); j++)
            check_val($sformatf("%s/led%0d", tag, j), led_out[32*j +: 32], m_led[j]);
`ifdef SENSOR_IRQ_EN
        check_val({tag, "/irq"}, 32'(irq), 32'(m_irq));
`endif
    endtask

    task automatic tick(input string tag);
        if (rnd_sensors && $urandom_range(0, 2) == 0) begin
            sensor_valid = NS'($urandom) & NS'($urandom);
            for (int i = 0; i < int'(NS); i++) sensor_data[32*i +: 32] = $urandom;
        end
        model_step();
        @(posedge clk);
        #1;
        sensor_valid = '0;
        check_outputs(tag);
    endtask

    task automatic bus_access(input logic [23:0] a, input logic [31:0] d, input logic [3:0] b,
                              input bit rd, input bit wr, input int hold, input string tag);
        address = a;
        data_in = d;
        be      = b;
        as      = 1'b1;
        rs_n    = !rd;
        ws_n    = !wr;
        for (int c = 0; c < hold; c++) tick(tag);
        as   = 1'b0;
        rs_n = 1'b1;
        ws_n = 1'b1;
        tick({tag, "/end"});
    endtask

    task automatic bus_read(input logic [23:0] a, input string tag);
        bus_access(a, 32'h0, 4'h0, 1'b1, 1'b0, 1, tag);
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] b,
                             input string tag);
        bus_access(a, d, b, 1'b0, 1'b1, 1, tag);
    endtask

    function automatic logic [23:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1, 2, 3: return 24'(4 * $urandom_range(0, NS + NL + 1));
            4:          return 24'($urandom_range(0, 4 * (NS + NL + 2)));
            default:    return 24'($urandom);
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        as           = 1'b0;
        rs_n         = 1'b1;
        ws_n         = 1'b1;
        address      = '0;
        data_in      = '0;
        be           = '0;
        sensor_valid = '0;
        sensor_data  = '0;
        rnd_sensors  = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        check_val("reset_dout", data_out, 32'hFEE1DEAD);
        rst_n = 1'b1;
        tick("idle");
        check_val("pre_read", data_out, 32'hFEE1DEAD);

        bus_read(24'h0, "rd0");
        check_val("rd0_val", data_out, 32'h0);

        bus_write(A_LED0, 32'hA5A5A5A5, 4'b0101, "led0_wr");
        check_val("led0_be", led_out[31:0], 32'h00A500A5);

        sensor_data[32*2 +: 32] = 32'h12345678;
        sensor_valid[2] = 1'b1;
        tick("cap2");
        bus_read(A_STATUS, "st1");
        check_val("status_first", data_out, 32'h4);
        bus_read(A_STATUS, "st2");
        check_val("status_second", data_out, 32'h0);
        bus_read(24'h8, "rd_s2");
        check_val("sensor2", data_out, 32'h12345678);

        // Held read strobe: one access only, re-captured bit must survive the hold
        sensor_valid[0] = 1'b1;
        tick("cap0");
        address = A_STATUS;
        as      = 1'b1;
        rs_n    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                address = 24'h8;
                sensor_valid[0] = 1'b1;
            end
            tick("hold");
        end
        check_val("hold_once", data_out, 32'h1);
        as   = 1'b0;
        rs_n = 1'b1;
        tick("hold_end");
        bus_read(A_STATUS, "st_after_hold");
        check_val("status_resticky", data_out, 32'h1);

        bus_read(24'h3, "misalign");
        check_val("unmapped_3", data_out, 32'h0BADADD0);
        bus_read(24'h0, "rd0b");
        bus_read(24'h400, "far");
        check_val("unmapped_400", data_out, 32'h0BADADD0);
        bus_write(24'h0, 32'hDEADBEEF, 4'hF, "wr_sensor");
        bus_read(24'h0, "rd_sensor0");
        check_val("sensor_ro", data_out, 32'h0);
        bus_write(A_STATUS, 32'hFFFFFFFF, 4'hF, "wr_status");
        bus_read(A_STATUS, "rd_status_ro");
        check_val("status_ro", data_out, 32'h0);

        bus_write(A_LED1, 32'hFFFFFFFF, 4'h0, "be0");
        check_val("be0_led1", led_out[63:32], 32'h0);
        bus_access(A_LED0, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 1, "rdwr");
        check_val("rdwr_read", data_out, 32'h00A500A5);
        check_val("rdwr_drop", led_out[31:0], 32'h00A500A5);

`ifdef SENSOR_IRQ_EN
        bus_write(A_MASK, 32'h1, 4'b0001, "mask_wr");
        sensor_valid[0] = 1'b1;
        tick("irq_set");
        check_val("irq_lag", 32'(irq), 32'h0);
        tick("irq_on");
        check_val("irq_on", 32'(irq), 32'h1);
        address = A_STATUS;
        as      = 1'b1;
        rs_n    = 1'b0;
        tick("irq_clr_rd");
        check_val("irq_hold", 32'(irq), 32'h1);
        as   = 1'b0;
        rs_n = 1'b1;
        tick("irq_clr");
        check_val("irq_off", 32'(irq), 32'h0);
`else
        bus_read(A_MASK, "mask_unmapped");
        check_val("mask_unmapped", data_out, 32'h0BADADD0);
`endif

        // Reset during an access, then a fresh access with strobes still held
        address = A_LED0;
        as      = 1'b1;
        rs_n    = 1'b0;
        tick("pre_rst_rd");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("mid_rst");
        check_val("mid_rst_dout", data_out, 32'hFEE1DEAD);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("fresh");
        check_val("fresh_read", data_out, 32'h0);
        as   = 1'b0;
        rs_n = 1'b1;
        tick("fresh_end");

        rnd_sensors = 1'b1;
        repeat (300) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 4)
                bus_access(rand_addr(), 32'h0, 4'h0, 1'b1, 1'b0,
                           int'($urandom_range(1, 3)), "rnd_rd");
            else if (op < 8)
                bus_access(rand_addr(), $urandom, 4'($urandom), 1'b0, 1'b1,
                           int'($urandom_range(1, 3)), "rnd_wr");
            else if (op == 8)
                bus_access(rand_addr(), $urandom, 4'($urandom), 1'b1, 1'b1, 1, "rnd_both");
            else
                tick("rnd_idle");
        end
        rnd_sensors = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
